xclk_seq: RTL and testbench

Reset/lock sequencer for the 18.432 MHz audio-clock PLL. Runs on the 50 MHz board clock and drives the PLL's active-high reset. It watches the PLL's asynchronous `locked` output and retries on lock timeout. It reports a qualified `clk_ready` that downstream logic in the 18.432 MHz domain uses to release its own reset. Loss of lock during operation re-sequences the PLL automatically.

---
 rtl/xclk_seq_pkg.sv | 30 +++
 rtl/sync2.sv | 34 +++
 rtl/xclk_seq.sv | 177 +++++++++++++++++
 tb/tb_xclk_seq.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/xclk_seq_pkg.sv
// -----------------------------------------------------------------------------
// xclk_seq_pkg
// Shared types and constants for the PLL reset/lock sequencer.
//   state_t    : sequencer states
//   LOST_CNT_W : width of the lock-loss event counter
//   RETRY_W    : width of the lock-timeout retry counter
//   max3       : constant helper used to size the shared down-counter
// -----------------------------------------------------------------------------
package xclk_seq_pkg;

  typedef enum logic [2:0] {
    RESET     = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_t;

  localparam int LOST_CNT_W = 8;
  localparam int RETRY_W    = 2;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/sync2.sv
// -----------------------------------------------------------------------------
// sync2
// Parameterized-width two-flop synchronizer with asynchronous active-low clear.
// Bring asynchronous level flags into the i_clk domain.
//   i_clk   : destination clock
//   i_rst_n : asynchronous active-low clear (both flops to 0)
//   i_d     : asynchronous input flags
//   o_q     : synchronized flags (two i_clk edges of latency)
// -----------------------------------------------------------------------------
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/xclk_seq.sv
// -----------------------------------------------------------------------------
// xclk_seq
// Reset/lock sequencer for the audio-clock PLL, running on the reference clock.
// Holds the PLL in reset, waits for lock with timeout/retry, qualifies lock for
// STABLE_CYCLES, then reports clk_ready. Loss of lock in RUN re-sequences.
//   clk        : reference clock (also the PLL refclk)
//   rst_n      : asynchronous active-low reset
//   restart    : one-cycle synchronous request to restart the sequence
//   pll_locked : PLL lock flag, asynchronous to clk
//   pll_rst    : PLL reset, active-high, registered
//   clk_ready  : PLL output qualified, registered
//   fail       : retries exhausted, sticky until restart or rst_n
//   retry_cnt  : lock timeouts in the current attempt series
//   lost_cnt   : saturating count of lock-loss events seen in RUN
// Build option: define XCLK_SEQ_LOST_CNT_EN to build the lock-loss counter;
// otherwise lost_cnt is tied to 0 and the state machine is identical.
// -----------------------------------------------------------------------------
module xclk_seq
  import xclk_seq_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRY     = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  restart,
  input  logic                  pll_locked,
  output logic                  pll_rst,
  output logic                  clk_ready,
  output logic                  fail,
  output logic [RETRY_W-1:0]    retry_cnt,
  output logic [LOST_CNT_W-1:0] lost_cnt
);

  localparam int MAX_CYC = max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  // Each state lasts (load value + 1) cycles. Out of async reset the first
  // edge already belongs to the RESET count, so the counter starts one higher.
  localparam logic [CNT_W-1:0]   RST_INIT  = CNT_W'(RST_CYCLES);
  localparam logic [CNT_W-1:0]   RST_LD    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TO_LD     = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STB_LD    = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_next;
  logic [RETRY_W-1:0] r_retry;
  logic [RETRY_W-1:0] w_retry_next;
  logic               r_pll_rst;
  logic               r_clk_ready;
  logic               r_fail;
  logic               w_lock_s;

  sync2 #(.WIDTH(1)) u_lock_sync (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_d     (pll_locked),
    .o_q     (w_lock_s)
  );

  always_comb begin
    w_next       = r_state;
    w_cnt_next   = r_cnt;
    w_retry_next = r_retry;
    unique case (r_state)
      RESET: begin
        if (r_cnt == '0) begin
          w_next     = WAIT_LOCK;
          w_cnt_next = TO_LD;
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      WAIT_LOCK: begin
        if (w_lock_s) begin
          w_next     = STABLE;
          w_cnt_next = STB_LD;
        end else if (r_cnt == '0) begin
          if (r_retry == RETRY_MAX) begin
            w_next     = FAIL;
            w_cnt_next = '0;
          end else begin
            w_next       = RESET;
            w_cnt_next   = RST_LD;
            w_retry_next = r_retry + RETRY_W'(1);
          end
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      STABLE: begin
        // Lock dropping during qualification is not a timeout: the retry
        // count is kept and a fresh lock wait begins.
        if (!w_lock_s) begin
          w_next     = WAIT_LOCK;
          w_cnt_next = TO_LD;
        end else if (r_cnt == '0) begin
          w_next       = RUN;
          w_cnt_next   = '0;
          w_retry_next = '0;
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      RUN: begin
        if (!w_lock_s) begin
          w_next     = RESET;
          w_cnt_next = RST_LD;
        end
      end
      FAIL: begin
        w_next = FAIL;
      end
      default: begin
        w_next     = RESET;
        w_cnt_next = RST_LD;
      end
    endcase

    if (restart) begin
      w_next       = RESET;
      w_cnt_next   = RST_LD;
      w_retry_next = '0;
    end
  end

  // Outputs are decoded from the next state so they switch on the same edge
  // as the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RESET;
      r_cnt       <= RST_INIT;
      r_retry     <= '0;
      r_pll_rst   <= 1'b1;
      r_clk_ready <= 1'b0;
      r_fail      <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_cnt       <= w_cnt_next;
      r_retry     <= w_retry_next;
      r_pll_rst   <= (w_next == RESET) || (w_next == FAIL);
      r_clk_ready <= (w_next == RUN);
      r_fail      <= (w_next == FAIL);
    end
  end

`ifdef XCLK_SEQ_LOST_CNT_EN
  logic                  w_lost_evt;
  logic [LOST_CNT_W-1:0] r_lost;

  // Counted even when restart wins the same cycle.
  assign w_lost_evt = (r_state == RUN) && !w_lock_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lost <= '0;
    end else if (w_lost_evt && (r_lost != '1)) begin
      r_lost <= r_lost + LOST_CNT_W'(1);
    end
  end

  assign lost_cnt = r_lost;
`else
  assign lost_cnt = '0;
`endif

  assign pll_rst   = r_pll_rst;
  assign clk_ready = r_clk_ready;
  assign fail      = r_fail;
  assign retry_cnt = r_retry;

endmodule

// File: tb/tb_xclk_seq.sv
// -----------------------------------------------------------------------------
// tb_xclk_seq
// Directed bench for xclk_seq with small timing parameters. A phase/elapsed
// model of the sequencing rules is compared with the DUT every cycle; literal
// cycle-exact expectations are checked at the points of interest.
// -----------------------------------------------------------------------------
module tb_xclk_seq;

  localparam int RST_C = 4;
  localparam int TO_C  = 20;
  localparam int STB_C = 8;
  localparam int MR_C  = 2;

  localparam int P_RST  = 0;
  localparam int P_WAIT = 1;
  localparam int P_STB  = 2;
  localparam int P_RUN  = 3;
  localparam int P_FAIL = 4;

`ifdef XCLK_SEQ_LOST_CNT_EN
  localparam int LOST_ONE = 1;
`else
  localparam int LOST_ONE = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       restart = 1'b0;
  logic       pll_locked = 1'b0;
  logic       pll_rst;
  logic       clk_ready;
  logic       fail;
  logic [1:0] retry_cnt;
  logic [7:0] lost_cnt;

  int n_pass  = 0;
  int n_total = 0;

  xclk_seq #(
    .RST_CYCLES    (RST_C),
    .LOCK_TIMEOUT  (TO_C),
    .STABLE_CYCLES (STB_C),
    .MAX_RETRY     (MR_C)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .restart    (restart),
    .pll_locked (pll_locked),
    .pll_rst    (pll_rst),
    .clk_ready  (clk_ready),
    .fail       (fail),
    .retry_cnt  (retry_cnt),
    .lost_cnt   (lost_cnt)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input int act, input int exp);
    n_total = n_total + 1;
    if (act == exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endfunction

  // Model: phase plus cycles elapsed in it, lock seen through two delay stages.
  int m_phase, m_el, m_retry, m_lost;
  bit m_s0, m_s1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= P_RST;
      m_el    <= -1;  // first edge after release is part of the RESET hold
      m_retry <= 0;
      m_lost  <= 0;
      m_s0    <= 1'b0;
      m_s1    <= 1'b0;
    end else begin : step
      int ph, el, rt, lo;
      bit lk;
      ph = m_phase; el = m_el + 1; rt = m_retry; lo = m_lost; lk = m_s1;
      case (ph)
        P_RST:  if (el == RST_C) begin ph = P_WAIT; el = 0; end
        P_WAIT: begin
          if (lk) begin ph = P_STB; el = 0; end
          else if (el == TO_C) begin
            el = 0;
            if (rt == MR_C) ph = P_FAIL;
            else begin rt = rt + 1; ph = P_RST; end
          end
        end
        P_STB: begin
          if (!lk) begin ph = P_WAIT; el = 0; end
          else if (el == STB_C) begin ph = P_RUN; el = 0; rt = 0; end
        end
        P_RUN: if (!lk) begin ph = P_RST; el = 0; lo = (lo < 255) ? lo + 1 : 255; end
        default: el = 0;
      endcase
      if (restart) begin ph = P_RST; el = 0; rt = 0; end
      m_phase <= ph; m_el <= el; m_retry <= rt; m_lost <= lo;
      m_s1 <= m_s0; m_s0 <= pll_locked;
    end
  end

  always @(negedge clk) begin
    chk("mdl_pll_rst",   int'(pll_rst),   int'(m_phase == P_RST || m_phase == P_FAIL));
    chk("mdl_clk_ready", int'(clk_ready), int'(m_phase == P_RUN));
    chk("mdl_fail",      int'(fail),      int'(m_phase == P_FAIL));
    chk("mdl_retry_cnt", int'(retry_cnt), m_retry);
    chk("mdl_lost_cnt",  int'(lost_cnt),  (LOST_ONE == 1) ? m_lost : 0);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int pulses;
    int prev;

    tick(2);
    chk("rst_pll_rst", int'(pll_rst), 1);
    chk("rst_clk_ready", int'(clk_ready), 0);
    chk("rst_fail", int'(fail), 0);
    chk("rst_retry", int'(retry_cnt), 0);
    chk("rst_lost", int'(lost_cnt), 0);

    // Power-up with lock arriving at cycle 6.
    rst_n = 1'b1;
    for (int c = 0; c <= 3; c++) begin
      tick(1);
      chk("t1_pll_rst_hold", int'(pll_rst), 1);
    end
    tick(1); chk("t1_pll_rst_fall_c4", int'(pll_rst), 0);
    tick(2); pll_locked = 1'b1;
    tick(10); chk("t1_ready_c16", int'(clk_ready), 0);
    tick(1);  chk("t1_ready_c17", int'(clk_ready), 1);
    chk("t1_retry", int'(retry_cnt), 0);

    // Restart with no lock at all: three timeouts into FAIL.
    restart = 1'b1; pll_locked = 1'b0;
    tick(1); restart = 1'b0;
    pulses = 0; prev = 0;
    for (int k = 0; k <= 71; k++) begin
      if (k > 0) tick(1);
      if (pll_rst && prev == 0) pulses++;
      prev = int'(pll_rst);
      if (k == 24) chk("t2_retry_1", int'(retry_cnt), 1);
      if (k == 48) chk("t2_retry_2", int'(retry_cnt), 2);
      if (k == 71) chk("t2_fail_before", int'(fail), 0);
    end
    chk("t2_rst_pulses", pulses, 3);
    tick(1);
    chk("t2_fail", int'(fail), 1);
    chk("t2_fail_pll_rst", int'(pll_rst), 1);
    chk("t2_fail_retry", int'(retry_cnt), 2);
    tick(10);
    chk("t2_fail_sticky", int'(fail), 1);
    chk("t2_pll_rst_steady", int'(pll_rst), 1);

    // Restart out of FAIL; PLL relocks once its reset is released.
    restart = 1'b1; pll_locked = 1'b1;
    tick(1); restart = 1'b0; pll_locked = 1'b0;
    chk("t3_fail_clr", int'(fail), 0);
    chk("t3_retry_clr", int'(retry_cnt), 0);
    tick(3); chk("t3_pll_rst_r3", int'(pll_rst), 1);
    tick(1); chk("t3_pll_rst_r4", int'(pll_rst), 0);
    pll_locked = 1'b1;
    tick(10); chk("t3_ready_r14", int'(clk_ready), 0);
    tick(1);  chk("t3_ready_r15", int'(clk_ready), 1);

    // Lock loss in RUN for 5 cycles.
    tick(2); pll_locked = 1'b0;
    tick(2); chk("t4_ready_d2", int'(clk_ready), 1);
    tick(1);
    chk("t4_ready_d3", int'(clk_ready), 0);
    chk("t4_pll_rst_d3", int'(pll_rst), 1);
    chk("t4_lost", int'(lost_cnt), LOST_ONE);
    tick(2); pll_locked = 1'b1;
    tick(10); chk("t4_ready_d15", int'(clk_ready), 0);
    tick(1);  chk("t4_ready_d16", int'(clk_ready), 1);

    // One timeout, then lock drops at stable count 5.
    restart = 1'b1; pll_locked = 1'b0;
    tick(1); restart = 1'b0;
    tick(28); pll_locked = 1'b1;
    tick(3); chk("t5_retry_stable", int'(retry_cnt), 1);
    tick(3); pll_locked = 1'b0;
    tick(3);
    chk("t5_retry_kept", int'(retry_cnt), 1);
    chk("t5_pll_rst", int'(pll_rst), 0);
    for (int k = 0; k < 3; k++) begin
      tick(1);
      chk("t5_ready_low", int'(clk_ready), 0);
    end
    pll_locked = 1'b1;

    // Asynchronous reset mid-STABLE.
    tick(6);
    chk("t6_pre_pll_rst", int'(pll_rst), 0);
    chk("t6_pre_retry", int'(retry_cnt), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_pll_rst", int'(pll_rst), 1);
    chk("t6_clk_ready", int'(clk_ready), 0);
    chk("t6_fail", int'(fail), 0);
    chk("t6_retry", int'(retry_cnt), 0);
    chk("t6_lost", int'(lost_cnt), 0);
    tick(2); rst_n = 1'b1;
    tick(3); chk("t6_after_pll_rst", int'(pll_rst), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
